// File: rtl/ov5640_pkg.sv
// ov5640_pkg: shared FSM encoding and default DVP timing constants for the OV5640 transmitter.
package ov5640_pkg;
  typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_BLANK  = 160;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_SYNC   = 4;
  localparam int DEF_V_BACK   = 16;
  localparam int DEF_V_FRONT  = 8;
  localparam int LINE_W       = 12;
endpackage

// File: rtl/ov5640_tx_timing.sv
// ov5640_tx_timing: column/line counters; line count restarts at the end of each FSM segment.
module ov5640_tx_timing
  import ov5640_pkg::*;
#(
  parameter int H_TOTAL = 2 * DEF_H_ACTIVE + DEF_H_BLANK,
  parameter int CW      = $clog2(H_TOTAL)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [LINE_W-1:0] seg_lines,
  output logic [CW-1:0]     col,
  output logic              seg_done
);
  logic [LINE_W-1:0] line;
  logic line_end;
  assign line_end = col == CW'(H_TOTAL - 1);
  assign seg_done = run && line_end && line == seg_lines - LINE_W'(1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col  <= '0;
      line <= '0;
    end else if (!run) begin
      col  <= '0;
      line <= '0;
    end else begin
      col  <= line_end ? '0 : col + CW'(1);
      line <= seg_done ? '0 : line_end ? line + LINE_W'(1) : line;
    end
  end
endmodule

// File: rtl/ov5640_dvp_tx.sv
// ov5640_dvp_tx: RGB565 stream to OV5640-style DVP (vsync/href/8-bit data, high byte first).
module ov5640_dvp_tx
  import ov5640_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_BLANK  = DEF_H_BLANK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK,
  parameter int V_FRONT  = DEF_V_FRONT
) (
  input  logic        ov5640_pclk,
  input  logic        s_rst_n,
  input  logic        en,
  input  logic        s_valid,
  input  logic [15:0] s_data,
  output logic        s_ready,
  output logic        ov5640_vsync,
  output logic        ov5640_href,
  output logic [7:0]  ov5640_data,
  output logic        frame_start,
  output logic        underrun
);
  localparam int H_TOTAL = 2 * H_ACTIVE + H_BLANK;
  localparam int CW      = $clog2(H_TOTAL);
  state_t state, state_nx;
  logic [CW-1:0] col;
  logic [LINE_W-1:0] seg_lines;
  logic seg_done, in_line, fs_nx;
  logic [7:0] lo;
  ov5640_tx_timing #(.H_TOTAL(H_TOTAL), .CW(CW)) u_timing (
    .clk      (ov5640_pclk),
    .rst_n    (s_rst_n),
    .run      (state != IDLE),
    .seg_lines(seg_lines),
    .col      (col),
    .seg_done (seg_done)
  );
  always_comb begin
    seg_lines = state == VSYNC  ? LINE_W'(V_SYNC) :
                state == VBACK  ? LINE_W'(V_BACK) :
                state == ACTIVE ? LINE_W'(V_ACTIVE) : LINE_W'(V_FRONT);
    state_nx  = state == IDLE   ? (en ? VSYNC : IDLE) :
                !seg_done       ? state :
                state == VSYNC  ? VBACK :
                state == VBACK  ? ACTIVE :
                state == ACTIVE ? VFRONT :
                en              ? VSYNC : IDLE;
    in_line   = state == ACTIVE && col < CW'(2 * H_ACTIVE);
    s_ready   = in_line && !col[0];
    fs_nx     = state_nx == VSYNC && state != VSYNC;
  end
  always_ff @(posedge ov5640_pclk or negedge s_rst_n) begin
    if (!s_rst_n) state <= IDLE;
    else state <= state_nx;
  end
  // Outputs lag the counters by one cycle, so href brackets exactly the bytes being driven.
  always_ff @(posedge ov5640_pclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      ov5640_vsync <= 1'b0;
      ov5640_href  <= 1'b0;
      ov5640_data  <= 8'h00;
      frame_start  <= 1'b0;
      underrun     <= 1'b0;
      lo           <= 8'h00;
    end else begin
      ov5640_vsync <= state_nx == VSYNC;
      ov5640_href  <= in_line;
      ov5640_data  <= s_ready ? (s_valid ? s_data[15:8] : 8'h00) : in_line ? lo : 8'h00;
      frame_start  <= fs_nx;
      underrun     <= fs_nx ? 1'b0 : (s_ready && !s_valid) ? 1'b1 : underrun;
      lo           <= s_ready ? (s_valid ? s_data[7:0] : 8'h00) : lo;
    end
  end
endmodule

// File: tb/tb_ov5640_dvp_tx.sv
// tb_ov5640_dvp_tx: directed table of frame-1 timing plus underrun, en-drop and mid-line reset sequences,
// with a byte-pairing receiver that compares recovered pixels against what was offered.
module tb_ov5640_dvp_tx;
  logic pclk = 1'b0;
  logic s_rst_n, en, s_valid;
  logic [15:0] s_data;
  logic s_ready, ov5640_vsync, ov5640_href, frame_start, underrun;
  logic [7:0] ov5640_data;

  typedef struct {
    int k;
    logic vs, hr, rdy, fs, u;
    logic [7:0] d;
  } vec_t;
  vec_t tbl[$];

  int checks = 0, failures = 0;
  int pi = 0, vs_cnt, hr_cnt, fs_cnt;
  logic overlap, have_hi;
  logic [7:0] hi;
  logic [15:0] pix[256];
  logic [15:0] exp_q[$];

  ov5640_dvp_tx #(.H_ACTIVE(4), .H_BLANK(4), .V_ACTIVE(2), .V_SYNC(1), .V_BACK(1), .V_FRONT(1)) dut (
    .ov5640_pclk (pclk),
    .s_rst_n     (s_rst_n),
    .en          (en),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .ov5640_vsync(ov5640_vsync),
    .ov5640_href (ov5640_href),
    .ov5640_data (ov5640_data),
    .frame_start (frame_start),
    .underrun    (underrun)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [12:0] outs();
    return {ov5640_vsync, ov5640_href, s_ready, frame_start, underrun, ov5640_data};
  endfunction

  function automatic void add(input int k, input logic vs, hr, rdy, fs, input logic [7:0] d);
    tbl.push_back('{k, vs, hr, rdy, fs, 1'b0, d});
  endfunction

  task automatic cyc(input logic v);
    logic hs;
    if (ov5640_vsync && ov5640_href) overlap = 1'b1;
    if (ov5640_vsync) vs_cnt++;
    if (frame_start) fs_cnt++;
    if (ov5640_href) begin
      hr_cnt++;
      if (!have_hi) begin
        hi = ov5640_data;
        have_hi = 1'b1;
      end else begin
        have_hi = 1'b0;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rx_extra: got pixel %h expected none", {hi, ov5640_data});
        end else chk("rx_pixel", {hi, ov5640_data}, exp_q.pop_front());
      end
    end
    s_valid = v;
    s_data = pix[pi];
    if (s_ready) exp_q.push_back(v ? pix[pi] : 16'h0000);
    hs = s_ready && v;
    @(posedge pclk);
    if (hs) pi++;
    @(negedge pclk);
  endtask

  task automatic clear_counts();
    vs_cnt = 0; hr_cnt = 0; fs_cnt = 0; overlap = 1'b0;
  endtask

  task automatic run_frame(input int bad, input int en_off, input int len);
    int slot = 0;
    logic exp_u = 1'b0, u_ok = 1'b1, v;
    clear_counts();
    chk("frame_start_j0", frame_start, 1);
    for (int j = 0; j < len; j++) begin
      if (j == en_off) en = 1'b0;
      if (underrun !== exp_u) u_ok = 1'b0;
      v = !(s_ready && slot == bad);
      if (s_ready) begin
        if (!v) exp_u = 1'b1;
        slot++;
      end
      cyc(v);
    end
    chk("underrun_track", u_ok, 1);
    if (len == 60) begin
      chk("vsync_cycles", vs_cnt, 12);
      chk("href_cycles", hr_cnt, 16);
      chk("frame_start_count", fs_cnt, 1);
      chk("vsync_href_overlap", overlap, 0);
    end
  endtask

  initial begin
    int idx;
    pix[0] = 16'hF81F; pix[1] = 16'h07E0; pix[2] = 16'h001F; pix[3] = 16'hFFFF;
    pix[4] = 16'h1234; pix[5] = 16'hABCD; pix[6] = 16'h5A5A; pix[7] = 16'h00FF;
    for (int i = 8; i < 256; i++) pix[i] = 16'(i * 40503 + 4660);
    add(0, 1, 0, 0, 1, 8'h00);  add(1, 1, 0, 0, 0, 8'h00);  add(11, 1, 0, 0, 0, 8'h00);
    add(12, 0, 0, 0, 0, 8'h00); add(23, 0, 0, 0, 0, 8'h00); add(24, 0, 0, 1, 0, 8'h00);
    add(25, 0, 1, 0, 0, 8'hF8); add(26, 0, 1, 1, 0, 8'h1F); add(27, 0, 1, 0, 0, 8'h07);
    add(28, 0, 1, 1, 0, 8'hE0); add(29, 0, 1, 0, 0, 8'h00); add(30, 0, 1, 1, 0, 8'h1F);
    add(31, 0, 1, 0, 0, 8'hFF); add(32, 0, 1, 0, 0, 8'hFF); add(33, 0, 0, 0, 0, 8'h00);
    add(35, 0, 0, 0, 0, 8'h00); add(36, 0, 0, 1, 0, 8'h00); add(37, 0, 1, 0, 0, 8'h12);
    add(38, 0, 1, 1, 0, 8'h34); add(39, 0, 1, 0, 0, 8'hAB); add(40, 0, 1, 1, 0, 8'hCD);
    add(41, 0, 1, 0, 0, 8'h5A); add(42, 0, 1, 1, 0, 8'h5A); add(43, 0, 1, 0, 0, 8'h00);
    add(44, 0, 1, 0, 0, 8'hFF); add(45, 0, 0, 0, 0, 8'h00); add(48, 0, 0, 0, 0, 8'h00);
    add(59, 0, 0, 0, 0, 8'h00);
    have_hi = 1'b0;
    clear_counts();
    s_rst_n = 1'b0; en = 1'b0; s_valid = 1'b0; s_data = 16'h0;
    repeat (2) @(negedge pclk);
    chk("reset_outputs", outs(), 0);
    s_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1);
      chk("idle_outputs", outs(), 0);
    end
    en = 1'b1;
    cyc(1'b1);
    // Frame 1: timing table, all pixels valid.
    clear_counts();
    idx = 0;
    for (int k = 0; k < 60; k++) begin
      if (idx < tbl.size() && tbl[idx].k == k) begin
        chk($sformatf("tbl_k%0d", k), outs(),
            {tbl[idx].vs, tbl[idx].hr, tbl[idx].rdy, tbl[idx].fs, tbl[idx].u, tbl[idx].d});
        idx++;
      end
      cyc(1'b1);
    end
    chk("f1_vsync_cycles", vs_cnt, 12);
    chk("f1_href_cycles", hr_cnt, 16);
    chk("f1_overlap", overlap, 0);
    // Frame 2: pixel slot 2 starved, en dropped in line 1; frame must still complete.
    run_frame(2, 40, 60);
    for (int i = 0; i < 5; i++) begin
      chk("post_drop_idle", {ov5640_vsync, ov5640_href, s_ready, frame_start, ov5640_data}, 0);
      chk("underrun_sticky", underrun, 1);
      cyc(1'b1);
    end
    en = 1'b1;
    cyc(1'b1);
    chk("reraise_vsync", ov5640_vsync, 1);
    chk("reraise_fs", frame_start, 1);
    chk("reraise_underrun_clear", underrun, 0);
    // Frame 3: starve slot 0, then assert reset mid-line.
    run_frame(0, -1, 27);
    chk("pre_reset_href", ov5640_href, 1);
    chk("pre_reset_underrun", underrun, 1);
    s_rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", outs(), 0);
    have_hi = 1'b0;
    exp_q.delete();
    @(negedge pclk);
    @(negedge pclk);
    s_rst_n = 1'b1;
    chk("post_reset_idle", outs(), 0);
    cyc(1'b1);
    chk("post_reset_vsync", ov5640_vsync, 1);
    run_frame(-1, -1, 60);
    chk("rx_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
